// File: rtl/muller_c_pkg.sv
// Shared types and defaults for the Muller C-element handshake controller.
package muller_c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RISE,
    WAIT_HI,
    FALL,
    WAIT_LO,
    RESP
  } mc_state_t;

  localparam int unsigned MC_SYNC_STAGES = 2;
  localparam int unsigned MC_TIMEOUT     = 15;

endpackage

// File: rtl/muller_c_sync.sv
// Multi-flop synchronizer bringing the self-timed C-element output into the clk domain.
module muller_c_sync
  import muller_c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = MC_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/muller_c_handshake_ctrl.sv
// Round-robin arbiter plus four-phase exercise FSM for a shared Muller C-element,
// reporting completion or timeout to the granted requester.
module muller_c_handshake_ctrl
  import muller_c_pkg::*;
#(
  parameter  int unsigned NREQ        = 2,
  parameter  int unsigned SYNC_STAGES = MC_SYNC_STAGES,
  parameter  int unsigned TIMEOUT     = MC_TIMEOUT,
  parameter  int unsigned TO_W        = 4,
  localparam int unsigned ID_W        = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] resp_valid,
  output logic            resp_err,
  output logic            c_a,
  output logic            c_b,
  input  logic            c_q,
  output logic            busy,
  output logic [ID_W-1:0] grant_id
);

  mc_state_t       state, state_next;
  logic [ID_W-1:0] ptr, ptr_next;
  logic [ID_W-1:0] grant_id_next;
  logic [TO_W-1:0] cnt, cnt_next, cnt_inc;
  logic            err, err_next;
  logic            drive, drive_next;
  logic            timeout_hit;
  logic            q_s;

  logic            found;
  logic [ID_W-1:0] win;
  logic [ID_W:0]   cand;

  muller_c_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (c_q),
    .q    (q_s)
  );

  // Priority search starting at the round-robin pointer, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (ID_W + 1)'(i);
      if (cand >= (ID_W + 1)'(NREQ)) begin
        cand = cand - (ID_W + 1)'(NREQ);
      end
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found = 1'b1;
        win   = cand[ID_W-1:0];
      end
    end
  end

  assign cnt_inc     = (cnt == TO_W'(TIMEOUT)) ? cnt : cnt + 1'b1;
  assign timeout_hit = (cnt_inc == TO_W'(TIMEOUT));

  // The element inputs are loaded on the edge that enters RISE/FALL, so the
  // pair is already driven during those one-cycle states.
  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    grant_id_next = grant_id;
    cnt_next      = cnt;
    err_next      = err;
    drive_next    = drive;
    req_ready     = '0;
    resp_valid    = '0;
    resp_err      = 1'b0;

    unique case (state)
      IDLE: begin
        if (found) begin
          req_ready     = NREQ'(1) << win;
          grant_id_next = win;
          ptr_next      = (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;
          drive_next    = 1'b1;
          state_next    = RISE;
        end
      end
      RISE: begin
        cnt_next   = '0;
        state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (q_s) begin
          drive_next = 1'b0;
          state_next = FALL;
        end else begin
          cnt_next = cnt_inc;
          if (timeout_hit) begin
            err_next   = 1'b1;
            drive_next = 1'b0;
            state_next = FALL;
          end
        end
      end
      FALL: begin
        cnt_next   = '0;
        state_next = WAIT_LO;
      end
      WAIT_LO: begin
        if (!q_s) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_inc;
          if (timeout_hit) begin
            err_next   = 1'b1;
            state_next = RESP;
          end
        end
      end
      RESP: begin
        resp_valid = NREQ'(1) << grant_id;
        resp_err   = err;
        err_next   = 1'b0;
        state_next = IDLE;
      end
      default: begin
        drive_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      cnt      <= '0;
      err      <= 1'b0;
      drive    <= 1'b0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      grant_id <= grant_id_next;
      cnt      <= cnt_next;
      err      <= err_next;
      drive    <= drive_next;
    end
  end

  assign c_a  = drive;
  assign c_b  = drive;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_muller_c_handshake_ctrl.sv
// Randomized bench: element model with programmable delay or stuck output,
// transaction-level reference for arbitration, latency and error reporting.
module tb_muller_c_handshake_ctrl;

  localparam int NREQ = 2;
  localparam int SYNC = 2;
  localparam int TO   = 15;
  localparam int TOW  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] resp_valid;
  logic            resp_err;
  logic            c_a, c_b, c_q;
  logic            busy;
  logic [0:0]      grant_id;

  int n_checks = 0;
  int n_pass   = 0;

  // element behaviour: 0 = follows inputs after el_delay cycles, 1 = stuck 0, 2 = stuck 1
  int         el_mode  = 0;
  int         el_delay = 0;
  logic [7:0] pipe = '0;
  int         ptr_m = 0;
  logic       prev_rv = 1'b0;

  always #5 clk = ~clk;

  muller_c_handshake_ctrl #(
    .NREQ(NREQ),
    .SYNC_STAGES(SYNC),
    .TIMEOUT(TO),
    .TO_W(TOW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_err(resp_err),
    .c_a(c_a),
    .c_b(c_b),
    .c_q(c_q),
    .busy(busy),
    .grant_id(grant_id)
  );

  always @(negedge clk) pipe <= {pipe[6:0], c_a & c_b};

  always_comb begin
    c_q = 1'b0;
    if (el_mode == 1)      c_q = 1'b0;
    else if (el_mode == 2) c_q = 1'b1;
    else if (el_delay == 0) c_q = c_a & c_b;
    else                   c_q = pipe[el_delay];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  always @(negedge clk) begin
    check("ab_equal", 32'(c_a ^ c_b), 32'd0);
    check("rv_onehot0", 32'($onehot0(resp_valid)), 32'd1);
    check("rv_no_repeat", 32'(prev_rv && (resp_valid != '0)), 32'd0);
    prev_rv <= (resp_valid != '0);
  end

  function automatic int pick(input logic [NREQ-1:0] pat, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (pat[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  // Drives one accepted transaction from the IDLE cycle through RESP.
  task automatic do_txn(input logic [NREQ-1:0] pat, input bit hold);
    int w, hi, lo, exp_lat, lat;
    bit exp_err, seen;
    w = pick(pat, ptr_m);
    ptr_m = (w + 1) % NREQ;
    if (el_mode == 1) begin
      hi = TO; lo = 1; exp_err = 1'b1;
    end else if (el_mode == 2) begin
      hi = 1; lo = TO; exp_err = 1'b1;
    end else begin
      hi = el_delay + SYNC; lo = el_delay + SYNC; exp_err = 1'b0;
    end
    exp_lat = 4 + hi + lo;

    @(negedge clk);
    req_valid = pat;
    #1;
    check("busy_idle", 32'(busy), 32'd0);
    check("req_ready", 32'(req_ready), 32'(1 << w));
    check("c_a_idle", 32'(c_a), 32'd0);
    @(negedge clk);
    if (!hold) req_valid = '0;
    check("c_a_rise", 32'(c_a), 32'd1);
    check("ready_off", 32'(req_ready), 32'd0);
    check("grant_id", 32'(grant_id), 32'(w));
    lat = 2;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (resp_valid != '0) seen = 1'b1;
    end
    check("resp_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_bit", 32'(resp_valid), 32'(1 << w));
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("c_a_end", 32'(c_a), 32'd0);
  endtask

  task automatic idle_gap(input int n);
    req_valid = '0;
    repeat (n) @(negedge clk);
    check("busy_gap", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [NREQ-1:0] pat;
    bit hold;
    req_valid = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_c_a", 32'(c_a), 32'd0);
    check("rst_c_b", 32'(c_b), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    rst_n = 1'b1;

    // both requesters held: grants alternate 0,1,0,1 back to back
    for (int i = 0; i < 4; i++) do_txn(2'b11, 1'b1);
    idle_gap(4);
    do_txn(2'b01, 1'b0);

    el_mode = 1;
    idle_gap(8);
    do_txn(2'b01, 1'b0);
    el_mode = 2;
    idle_gap(8);
    do_txn(2'b10, 1'b0);

    for (int i = 0; i < 24; i++) begin
      el_mode  = ($urandom_range(0, 9) < 2) ? 1 + int'($urandom_range(0, 1)) : 0;
      el_delay = int'($urandom_range(0, 4));
      idle_gap(8);
      pat  = NREQ'($urandom_range(1, 3));
      hold = 1'($urandom_range(0, 1));
      do_txn(pat, hold);
    end

    // reset mid-transaction, grant held by requester 1 during WAIT_HI
    el_mode = 1;
    idle_gap(8);
    @(negedge clk);
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("c_a_pre_rst", 32'(c_a), 32'd1);
    check("grant_pre_rst", 32'(grant_id), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_c_a", 32'(c_a), 32'd0);
    check("rst_async_c_b", 32'(c_b), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_gid", 32'(grant_id), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("no_resp_after_rst", 32'(resp_valid), 32'd0);
    end
    el_mode = 0;
    el_delay = 0;
    do_txn(2'b11, 1'b0);
    idle_gap(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
